sc_intc: RTL

- Parametrised N-channel vectored interrupt controller in front of the single-cycle interrupt CPU.
- Collects NCH device requests with per-channel mask and edge/level mode, then arbitrates by fixed or rotating priority.
- Drives the CPU's single intr line, takes inta as acknowledge, supplies a handler vector, and holds the channel in service until the CPU signals end-of-interrupt (eret).
- Adds multi-channel, masking, vectoring and rotation, none of which the single intr/inta pair has.

---
 rtl/sc_intc.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sc_intc.sv
// sc_intc: N-channel vectored interrupt controller in front of a CPU that
// has a single intr/inta pair. Each channel has a mask bit and an edge/level
// mode bit. Fixed priority has channel 0 highest. Rotating priority starts
// its search one past the last channel served. The chosen channel is held
// in REQ until the CPU acknowledges, and then in SERV until eret.
//
// Ports:
//   clk, clr    clock; synchronous active-high reset
//   irq         device requests, already synchronous to clk
//   we/addr     register write strobe and select
//                 0 MASK, 1 MODE, 2 PEND (W1C on edge channels), 3 STATUS
//   wdata       write data; the low NCH bits are used
//   rdata       combinational read of the register selected by addr
//   intr        interrupt request to the CPU
//   inta        acknowledge from the CPU
//   eret        end-of-interrupt pulse from the CPU
//   vector      handler address VEC_BASE + cur_id * VEC_STRIDE
//   in_service  high from acknowledge until eret
module sc_intc #(
    parameter int unsigned     NCH        = 8,
    parameter int unsigned     ROTATE     = 0,
    parameter logic [NCH-1:0]  MODE_RST   = '1,
    parameter logic [31:0]     VEC_BASE   = 32'h0000_0008,
    parameter logic [31:0]     VEC_STRIDE = 32'd4
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [NCH-1:0] irq,
    input  logic           we,
    input  logic [1:0]     addr,
    input  logic [31:0]    wdata,
    output logic [31:0]    rdata,
    output logic           intr,
    input  logic           inta,
    input  logic           eret,
    output logic [31:0]    vector,
    output logic           in_service
);

    typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

    localparam logic [NCH-1:0] ONE  = {{(NCH-1){1'b0}}, 1'b1};
    localparam logic [5:0]     NCH6 = 6'(NCH);

    state_t         state_q, state_d;
    logic [NCH-1:0] mask_q, mode_q, pend_q, irq_d;
    logic [4:0]     cur_id_q, cur_id_d, ptr_q, ptr_d;

    logic [NCH-1:0]   rise, pend_view, eligible, wr_clr, ack_clr;
    logic [2*NCH-1:0] dbl;
    logic [NCH-1:0]   rotated;
    logic [4:0]       start, off, winner;
    logic [5:0]       sum;
    logic             found, ack;
    logic             unused_bits;

    // Edge channels report the latched pending bit. Level channels report
    // the live request line.
    assign rise      = irq & ~irq_d;
    assign pend_view = (pend_q & mode_q) | (irq & ~mode_q);
    assign eligible  = pend_view & mask_q;

    assign ack     = (state_q == REQ) && inta;
    assign wr_clr  = (we && addr == 2'd2) ? wdata[NCH-1:0] : '0;
    assign ack_clr = ack ? (ONE << cur_id_q) : '0;

    assign intr       = (state_q == REQ);
    assign in_service = (state_q == SERV);
    assign vector     = VEC_BASE + 32'(cur_id_q) * VEC_STRIDE;

    // Parity sink for bits that are not otherwise used.
    assign unused_bits = ^{wdata, dbl};

    // Rotate the eligible set so that the search start sits at bit 0. Take
    // the lowest set bit, then map it back to a channel number modulo NCH.
    always_comb begin
        start = 5'd0;
        if (ROTATE != 0) start = ptr_q;
        dbl     = {eligible, eligible} >> start;
        rotated = dbl[NCH-1:0];
        found   = 1'b0;
        off     = 5'd0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (!found && rotated[k]) begin
                found = 1'b1;
                off   = 5'(k);
            end
        end
        sum    = {1'b0, start} + {1'b0, off};
        winner = (sum >= NCH6) ? 5'(sum - NCH6) : sum[4:0];
    end

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        ptr_d    = ptr_q;
        unique case (state_q)
            IDLE: if (|eligible) begin
                state_d  = REQ;
                cur_id_d = winner;
            end
            REQ:  if (inta) state_d = SERV;
            SERV: if (eret) begin
                state_d = IDLE;
                ptr_d   = ({1'b0, cur_id_q} == NCH6 - 6'd1) ? 5'd0 : cur_id_q + 5'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            mode_q   <= MODE_RST;
            pend_q   <= '0;
            irq_d    <= '0;
            cur_id_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
            ptr_q    <= ptr_d;
            irq_d    <= irq;
            if (we && addr == 2'd0) mask_q <= wdata[NCH-1:0];
            if (we && addr == 2'd1) mode_q <= wdata[NCH-1:0];
            // When a set and a clear hit the same bit, the set wins. The
            // register only holds edge channels; level bits stay at zero.
            pend_q <= ((pend_q & ~(wr_clr | ack_clr)) | rise) & mode_q;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (addr)
            2'd0: rdata[NCH-1:0] = mask_q;
            2'd1: rdata[NCH-1:0] = mode_q;
            2'd2: rdata[NCH-1:0] = pend_view;
            default: begin
                rdata[31]  = in_service;
                rdata[30]  = intr;
                rdata[4:0] = cur_id_q;
            end
        endcase
    end

endmodule
